// File: rtl/ps2_frame_receiver_if.sv
// Bundles the PS/2 pins and the decoded keyboard byte stream.
// The slave side is the receiver; the master side is the device/consumer side.
interface ps2_frame_receiver_if;
    logic       PS2_clk;
    logic       PS2_DAT;
    logic [7:0] data;
    logic       data_valid;
    logic       extended;
    logic       rx_error;

    modport master (
        output PS2_clk,
        output PS2_DAT,
        input  data,
        input  data_valid,
        input  extended,
        input  rx_error
    );

    modport slave (
        input  PS2_clk,
        input  PS2_DAT,
        output data,
        output data_valid,
        output extended,
        output rx_error
    );
endinterface

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host receiver: pin conditioning, 11-bit frame deserialiser with timeout,
// and a scan-code decoder that forwards only make codes (tagged when preceded by E0).
module ps2_frame_receiver #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input logic                 Clock,
    input logic                 Reset,
    ps2_frame_receiver_if.slave bus
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StData   = 2'd1;
    localparam logic [1:0] StParity = 2'd2;
    localparam logic [1:0] StStop   = 2'd3;

    localparam logic [7:0] CodeExt = 8'hE0;
    localparam logic [7:0] CodeBrk = 8'hF0;

    // Synchronisers preset to the idle-bus level.
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_s;
    logic                   dat_s;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], bus.PS2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], bus.PS2_DAT};
        end
    end

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];

    // Clock deglitch: fclk follows clk_s only after FILTER_LEN consecutive differing samples.
    logic          fclk_q;
    logic          fclk_prev_q;
    logic          fall_q;
    logic [FW-1:0] filt_cnt_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            fclk_q      <= 1'b1;
            fclk_prev_q <= 1'b1;
            fall_q      <= 1'b0;
            filt_cnt_q  <= '0;
        end else begin
            fclk_prev_q <= fclk_q;
            fall_q      <= fclk_prev_q & ~fclk_q;
            if (clk_s == fclk_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_LAST) begin
                fclk_q     <= clk_s;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    // Frame state, timeout and decoder.
    logic [1:0]    state_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    shift_q;
    logic          par_bit_q;
    logic [TW-1:0] to_cnt_q;
    logic          ext_pend_q;
    logic          brk_pend_q;
    logic [7:0]    data_q;
    logic          data_valid_q;
    logic          extended_q;
    logic          rx_error_q;

    logic timeout;
    logic parity_ok;
    logic frame_ok;

    always_comb begin
        timeout   = 1'b0;
        parity_ok = 1'b0;
        frame_ok  = 1'b0;
        // A fall in the same cycle takes priority over the timeout.
        timeout   = (state_q != StIdle) && (to_cnt_q == TO_LAST) && !fall_q;
        parity_ok = ^{shift_q, par_bit_q};
        frame_ok  = dat_s && parity_ok;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= StIdle;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            to_cnt_q     <= '0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            extended_q   <= 1'b0;
            rx_error_q   <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            rx_error_q   <= 1'b0;

            if (fall_q) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q != TO_LAST) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end

            if (timeout) begin
                state_q    <= StIdle;
                bitcnt_q   <= '0;
                shift_q    <= '0;
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
            end else if (fall_q) begin
                unique case (state_q)
                    StIdle: begin
                        if (!dat_s) begin
                            state_q  <= StData;
                            bitcnt_q <= '0;
                        end
                    end
                    StData: begin
                        shift_q  <= {dat_s, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == 3'd7) begin
                            state_q <= StParity;
                        end
                    end
                    StParity: begin
                        par_bit_q <= dat_s;
                        state_q   <= StStop;
                    end
                    StStop: begin
                        state_q <= StIdle;
                        if (!frame_ok) begin
                            rx_error_q <= 1'b1;
                        end else if (shift_q == CodeExt) begin
                            ext_pend_q <= 1'b1;
                        end else if (shift_q == CodeBrk) begin
                            brk_pend_q <= 1'b1;
                        end else if (brk_pend_q) begin
                            // Break code: swallow it and forget any E0 prefix.
                            ext_pend_q <= 1'b0;
                            brk_pend_q <= 1'b0;
                        end else begin
                            data_q       <= shift_q;
                            extended_q   <= ext_pend_q;
                            data_valid_q <= 1'b1;
                            ext_pend_q   <= 1'b0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.extended   = extended_q;
    assign bus.rx_error   = rx_error_q;

endmodule
